fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the pipelined RV32 core with float extension. It sits directly upstream of decode and the control unit. It owns the PC and issues word reads to instruction memory over a req/gnt/rvalid handshake. Returned instructions are buffered in a small FIFO and presented to decode with a valid/ready handshake. Branch/jump redirects from execute flush the buffer and discard any in-flight response.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- DEPTH, 2, instruction buffer entries (power of two, ≥2)
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  read request valid
- imem_addr  out  32  word-aligned fetch address, bits[1:0] always 0
- imem_gnt  in  1  request accepted this cycle when imem_req=1
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  instruction word
- redirect_valid  in  1  taken branch/JAL/JALR from execute
- redirect_pc  in  32  new PC; bits[1:0] forced to 0
- id_valid  out  1  id_instr/id_pc hold a valid instruction
- id_ready  in  1  decode accepts this cycle
- id_instr  out  32  instruction word
- id_pc  out  32  PC of id_instr
- id_opcode  out  7  id_instr[6:0], drives control-unit opcode

## Operation
- States: IDLE, REQ, WAIT. Reset enters IDLE with pc=RESET_PC, FIFO empty, drop=0.
- IDLE → REQ when count + outstanding < DEPTH. REQ holds imem_req=1, imem_addr=pc.
- REQ and imem_gnt=1 → WAIT. The granted address is recorded as resp_pc, and pc advances by 4.
- WAIT and imem_rvalid=1 → push {rdata, resp_pc} unless drop=1. Then clear drop and go to REQ if space remains, otherwise IDLE.
- At most one outstanding request.
- FIFO rules:
  - Pop when id_valid & id_ready.
  - Push and pop in the same cycle are both legal, including when the FIFO is full.
  - Pointers wrap mod DEPTH.
- Outputs always reflect the FIFO head. id_valid = (count≠0).
- Redirect (highest priority, any state):
  - FIFO is flushed. A same-cycle pop is ignored and a same-cycle push is discarded.
  - pc <= redirect_pc.
  - In WAIT, or in REQ with imem_gnt=1 that cycle: drop <= 1 and the next rvalid is discarded.
  - In REQ without gnt: imem_addr changes to the new pc next cycle. The imem protocol permits changing an un-granted address.
  - Next state is REQ when no response is pending, otherwise WAIT with drop=1.
- A redirect arriving while drop=1 only updates pc; drop stays 1.
- imem_rvalid outside WAIT is ignored.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, id_valid=0, id_instr=32'h0000_0013 (NOP), id_pc=RESET_PC, id_opcode=7'b0010011.
- First imem_req=1 occurs in the first cycle after rst_n deasserts.
- Latency: imem_rvalid at cycle t → id_valid=1 at t+1 (registered FIFO).
- Peak throughput is one instruction per 2 cycles (gnt in the REQ cycle, rvalid in the next cycle).
- Redirect at cycle t:
  - id_valid=0 at t+1.
  - imem_addr=redirect_pc at t+1 when no response is pending.
- Backpressure: with id_ready=0, at most DEPTH instructions are buffered. No request is issued while count + outstanding = DEPTH.
- rst_n asserted mid-transaction aborts immediately. Any imem_rvalid after reset release without a new grant is ignored.

## Structure
- Shared package core_pkg:
  - Opcode constants OPC_RTYPE, OPC_LOAD, OPC_ITYPE, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_AUIPC, OPC_LUI, OPC_JAL, OPC_CSR, OPC_FLW, OPC_FSW, OPC_FP. These are shared with the control unit.
  - NOP_INSTR constant.
  - fetch_state_e enum {IDLE, REQ, WAIT}.
- Sub-module fetch_fifo: DEPTH-entry synchronous FIFO of {instr, pc} with flush, push, pop, count, and full/empty flags.
- FSM, PC and drop logic live in fetch_unit.

## Test plan
- Reset release, imem_gnt=1 always, rvalid one cycle after gnt, id_ready=1 → id_pc sequence 0x0, 0x4, 0x8, delivered every 2 cycles; rdata passes to id_instr, id_opcode = rdata[6:0].
- id_ready=0 held for 10 cycles → exactly 2 instructions buffered (pc 0x0, 0x4), no further imem_req. Raising id_ready drains them in order, then fetching resumes at 0x8.
- Redirect to 0x100 in WAIT → id_valid=0 next cycle; the pending response (word at 0x8) is dropped; next granted address is 0x100 and id_pc=0x100.
- Redirect to 0x203 in REQ without gnt → imem_addr=0x200 next cycle; nothing is dropped.
- Redirect in the same cycle as imem_gnt and a FIFO pop → FIFO empty, the granted response is discarded, the next fetch comes from redirect_pc.
- rst_n pulsed low while in WAIT → all outputs return to reset values; a stray rvalid after release is ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: RV32/F opcodes used by decode and the control
// unit, the canonical NOP, fetch FSM states and the fetch buffer entry.
package core_pkg;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_CSR    = 7'b1110011;
  localparam logic [6:0] OPC_FLW    = 7'b0000111;
  localparam logic [6:0] OPC_FSW    = 7'b0100111;
  localparam logic [6:0] OPC_FP     = 7'b1010011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory port, redirect input from
// execute and the valid/ready port towards decode.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  id_opcode;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc,
    output id_valid, id_instr, id_pc, id_opcode,
    input  id_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc,
    input  id_valid, id_instr, id_pc, id_opcode,
    output id_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Instruction buffer between fetch and decode: DEPTH entries of
// {instr, pc}, synchronous flush, simultaneous push/pop allowed even when
// full. Entries reset to a NOP at the reset PC so the head is defined.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  fetch_entry_t             din,
  output fetch_entry_t             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t    mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic            do_push_s;
  logic            do_pop_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign dout      = mem_r[rd_ptr_r];
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Storage, pointers and occupancy; flush empties the buffer and wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '{instr: NOP_INSTR, pc: word_align(RESET_PC)};
      end
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one outstanding word read
// at a time to instruction memory, buffers returned words and hands them
// to decode. Redirects flush the buffer and squash any in-flight response.
module fetch_unit
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_r;
  logic [31:0]   pc_r;
  logic [31:0]   resp_pc_r;
  logic          drop_r;
  logic          req_r;

  logic [31:0]   redir_pc_s;
  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          empty_s;
  logic          space_s;
  logic [CW-1:0] count_s;
  logic [CW-1:0] count_after_s;
  fetch_entry_t  push_entry_s;
  fetch_entry_t  head_s;

  assign redir_pc_s   = word_align(bus.redirect_pc);
  assign pop_s        = ~empty_s & bus.id_ready;
  // A response is kept only in WAIT, when not squashed and not flushed this cycle.
  assign push_s       = (state_r == WAIT) & bus.imem_rvalid & ~drop_r & ~bus.redirect_valid;
  assign push_entry_s = '{instr: bus.imem_rdata, pc: resp_pc_r};

  // Occupancy after this cycle's push/pop decides whether another request fits.
  always_comb begin
    count_after_s = count_s + CW'(push_s) - CW'(pop_s);
    if (count_after_s < CW'(DEPTH)) begin
      space_s = 1'b1;
    end else begin
      space_s = 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.redirect_valid),
    .push  (push_s),
    .pop   (pop_s),
    .din   (push_entry_s),
    .dout  (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Fetch FSM with PC, squash flag and registered request; redirect has top priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      pc_r      <= word_align(RESET_PC);
      resp_pc_r <= word_align(RESET_PC);
      drop_r    <= 1'b0;
      req_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.redirect_valid) begin
            pc_r    <= redir_pc_s;
            state_r <= REQ;
            req_r   <= 1'b1;
          end else if (!full_s) begin
            state_r <= REQ;
            req_r   <= 1'b1;
          end else begin
            state_r <= IDLE;
            req_r   <= 1'b0;
          end
        end
        REQ: begin
          if (bus.redirect_valid) begin
            pc_r <= redir_pc_s;
            if (bus.imem_gnt) begin
              // The granted word belongs to the old path: squash it on return.
              drop_r  <= 1'b1;
              state_r <= WAIT;
              req_r   <= 1'b0;
            end else begin
              state_r <= REQ;
              req_r   <= 1'b1;
            end
          end else if (bus.imem_gnt) begin
            resp_pc_r <= pc_r;
            pc_r      <= pc_r + 32'd4;
            state_r   <= WAIT;
            req_r     <= 1'b0;
          end else begin
            state_r <= REQ;
            req_r   <= 1'b1;
          end
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            // Response consumed (or squashed) this cycle, nothing left in flight.
            drop_r <= 1'b0;
            if (bus.redirect_valid) begin
              pc_r    <= redir_pc_s;
              state_r <= REQ;
              req_r   <= 1'b1;
            end else if (space_s) begin
              state_r <= REQ;
              req_r   <= 1'b1;
            end else begin
              state_r <= IDLE;
              req_r   <= 1'b0;
            end
          end else if (bus.redirect_valid) begin
            pc_r    <= redir_pc_s;
            drop_r  <= 1'b1;
            state_r <= WAIT;
            req_r   <= 1'b0;
          end else begin
            state_r <= WAIT;
            req_r   <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          req_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req  = req_r;
  assign bus.imem_addr = pc_r;
  assign bus.id_valid  = ~empty_s;
  assign bus.id_instr  = head_s.instr;
  assign bus.id_pc     = head_s.pc;
  assign bus.id_opcode = head_s.instr[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a latency-configurable instruction memory model,
// a scoreboard of expected PCs checked whenever decode accepts a word,
// and directed scenarios for streaming, backpressure, redirects and reset.
module tb_fetch_unit;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic        gnt_en    = 1'b1;
  logic        resp_v    = 1'b0;
  logic        stray_v   = 1'b0;
  logic [31:0] resp_data = 32'h0;
  logic        ready     = 1'b0;
  logic        redir_v   = 1'b0;
  logic [31:0] redir_pc  = 32'h0;

  assign bus.imem_gnt       = gnt_en;
  assign bus.imem_rvalid    = resp_v | stray_v;
  assign bus.imem_rdata     = stray_v ? 32'hDEAD_BEEF : resp_data;
  assign bus.id_ready       = ready;
  assign bus.redirect_valid = redir_v;
  assign bus.redirect_pc    = redir_pc;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Memory contents: address-derived word with a real opcode in [6:0].
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    logic [6:0] op;
    case (a[4:2])
      3'd0: op = 7'b0110011;
      3'd1: op = 7'b0000011;
      3'd2: op = 7'b0010011;
      3'd3: op = 7'b1100111;
      3'd4: op = 7'b0100011;
      3'd5: op = 7'b1100011;
      3'd6: op = 7'b0010111;
      default: op = 7'b1010011;
    endcase
    return {a[24:0], op};
  endfunction

  // Memory responder: grant sampled at the edge, data returned lat cycles later.
  int          lat = 0;
  int          pdly = 0;
  logic        pv = 1'b0;
  logic [31:0] pa = 32'h0;
  logic        gnt_seen = 1'b0;
  logic [31:0] gnt_addr = 32'h0;
  int          n_grants = 0;

  initial begin
    forever begin
      @(posedge clk);
      gnt_seen = bus.imem_req & bus.imem_gnt;
      if (gnt_seen) begin
        gnt_addr = bus.imem_addr;
        pa       = bus.imem_addr;
        pv       = 1'b1;
        pdly     = lat;
        n_grants++;
      end
      #1;
      if (pv && pdly == 0) begin
        resp_v    = 1'b1;
        resp_data = instr_of(pa);
        pv        = 1'b0;
      end else begin
        resp_v = 1'b0;
        if (pv) pdly--;
      end
    end
  end

  // Scoreboard monitor: every accepted instruction pops one expected PC.
  logic [31:0] exp_q[$];
  int          dcyc[$];
  int          cyc = 0;

  initial begin
    logic [31:0] e;
    logic [31:0] ei;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n && bus.id_valid && ready && !redir_v) begin
        dcyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_delivery", bus.id_pc, 32'hFFFF_FFFF);
        end else begin
          e  = exp_q.pop_front();
          ei = instr_of(e);
          check_eq("id_pc", bus.id_pc, e);
          check_eq("id_instr", bus.id_instr, ei);
          check_eq("id_opcode", {25'd0, bus.id_opcode}, {25'd0, ei[6:0]});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_req"},    {31'd0, bus.imem_req}, 32'd0);
    check_eq({tag, "_addr"},   bus.imem_addr, 32'h0000_0000);
    check_eq({tag, "_valid"},  {31'd0, bus.id_valid}, 32'd0);
    check_eq({tag, "_instr"},  bus.id_instr, 32'h0000_0013);
    check_eq({tag, "_pc"},     bus.id_pc, 32'h0000_0000);
    check_eq({tag, "_opcode"}, {25'd0, bus.id_opcode}, 32'h0000_0013);
  endtask

  // Reset pulse; returns in the first cycle after release.
  task automatic do_reset(input logic g);
    step();
    rst_n   = 1'b0;
    ready   = 1'b0;
    redir_v = 1'b0;
    stray_v = 1'b0;
    gnt_en  = g;
    lat     = 0;
    pv      = 1'b0;
    step();
    check_reset_vals("reset");
    step();
    exp_q.delete();
    dcyc.delete();
    n_grants = 0;
    rst_n    = 1'b1;
    step();
    check_eq("first_req", {31'd0, bus.imem_req}, 32'd1);
    check_eq("first_addr", bus.imem_addr, 32'h0000_0000);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      step();
      i++;
    end
    check_eq({tag, "_drained"}, exp_q.size(), 32'd0);
  endtask

  task automatic wait_grant(input string tag, input logic [31:0] addr, input int budget);
    logic found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (gnt_seen && gnt_addr == addr) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check_eq({tag, "_grant"}, {31'd0, found}, 32'd1);
  endtask

  initial begin
    int saved;
    logic ok;

    // Streaming: one instruction every 2 cycles, in order.
    do_reset(1'b1);
    ready = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    wait_drain("stream", 60);
    ready = 1'b0;
    check_eq("stream_count", dcyc.size(), 32'd4);
    for (int i = 1; i < dcyc.size(); i++) begin
      check_eq("stream_gap", dcyc[i] - dcyc[i-1], 32'd2);
    end

    // Backpressure: buffer fills to DEPTH, then fetching stops.
    do_reset(1'b1);
    repeat (10) step();
    check_eq("bp_grants", n_grants, 32'd2);
    check_eq("bp_valid", {31'd0, bus.id_valid}, 32'd1);
    check_eq("bp_no_req", {31'd0, bus.imem_req}, 32'd0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    ready = 1'b1;
    wait_drain("bp", 40);
    ready = 1'b0;

    // Redirect while waiting for the word at 0x8.
    do_reset(1'b1);
    lat   = 1;
    ready = 1'b1;
    exp_q.push_back(32'h0);
    wait_drain("wait_pre", 30);
    ready = 1'b0;
    wait_grant("wait_8", 32'h8, 30);
    redir_v  = 1'b1;
    redir_pc = 32'h100;
    saved    = n_grants;
    step();
    redir_v = 1'b0;
    check_eq("wait_flush_valid", {31'd0, bus.id_valid}, 32'd0);
    wait_grant("wait_100", 32'h100, 20);
    check_eq("wait_next_grant", n_grants, saved + 1);
    exp_q.push_back(32'h100);
    ready = 1'b1;
    wait_drain("wait_post", 30);
    ready = 1'b0;

    // Redirect to an unaligned target while a request is not yet granted.
    do_reset(1'b0);
    ready    = 1'b1;
    redir_v  = 1'b1;
    redir_pc = 32'h203;
    step();
    redir_v = 1'b0;
    check_eq("req_redir_req", {31'd0, bus.imem_req}, 32'd1);
    check_eq("req_redir_addr", bus.imem_addr, 32'h200);
    check_eq("req_redir_nogrant", n_grants, 32'd0);
    gnt_en = 1'b1;
    exp_q.push_back(32'h200); exp_q.push_back(32'h204);
    wait_drain("req_redir", 40);
    ready = 1'b0;

    // Redirect together with a grant and a pop.
    do_reset(1'b1);
    ready = 1'b1;
    ok    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.id_valid && bus.imem_req) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check_eq("gnt_redir_setup", {31'd0, ok}, 32'd1);
    saved    = n_grants;
    redir_v  = 1'b1;
    redir_pc = 32'h300;
    step();
    redir_v = 1'b0;
    check_eq("gnt_redir_flush", {31'd0, bus.id_valid}, 32'd0);
    wait_grant("gnt_redir_300", 32'h300, 20);
    check_eq("gnt_redir_grants", n_grants, saved + 2);
    exp_q.push_back(32'h300);
    wait_drain("gnt_redir", 30);
    ready = 1'b0;

    // Reset in the middle of a transaction, then a stray response.
    do_reset(1'b1);
    lat = 1;
    wait_grant("rst_0", 32'h0, 10);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midreset");
    step();
    gnt_en = 1'b0;
    rst_n  = 1'b1;
    step();
    check_eq("rst_restart_req", {31'd0, bus.imem_req}, 32'd1);
    check_eq("rst_restart_addr", bus.imem_addr, 32'h0);
    stray_v = 1'b1;
    step();
    stray_v = 1'b0;
    check_eq("stray_ignored", {31'd0, bus.id_valid}, 32'd0);
    check_eq("stray_addr", bus.imem_addr, 32'h0);
    gnt_en = 1'b1;
    ready  = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    wait_drain("rst_refetch", 40);
    ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
